// File: rtl/incr_share_arbiter.sv
// Round-robin arbiter that time-shares one registered +1 incrementer between
// a full-width lane A and a (WIDTH-1)-bit lane B.
`ifndef WIDTH
`define WIDTH 8
`endif

module incr_share_arbiter #(
  parameter int WIDTH = `WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_a,
  input  logic [WIDTH-1:0] a_in,
  input  logic             req_b,
  input  logic [WIDTH-2:0] b_in,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic             done_a,
  output logic             done_b,
  output logic [WIDTH-1:0] result_a,
  output logic [WIDTH-2:0] result_b,
  output logic             ovf_a,
  output logic             ovf_b,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic LANE_A = 1'b0;
  localparam logic LANE_B = 1'b1;

  state_t           state_r, state_s;
  logic             last_r, last_s;
  logic             lane_r, lane_s;
  logic [WIDTH-1:0] opnd_r, opnd_s;
  logic             grant_s, win_b_s;
  logic [WIDTH-1:0] sum_s;

  logic             gnt_a_s, gnt_b_s, done_a_s, done_b_s;
  logic [WIDTH-1:0] result_a_s;
  logic [WIDTH-2:0] result_b_s;
  logic             ovf_a_s, ovf_b_s, busy_s;

  // Wrap detection at the width of the lane that owns the operand.
  function automatic logic all_ones(input logic [WIDTH-1:0] v, input logic narrow);
    if (narrow) begin
      all_ones = &v[WIDTH-2:0];
    end else begin
      all_ones = &v;
    end
  endfunction

  assign sum_s = opnd_r + {{(WIDTH-1){1'b0}}, 1'b1};

  // Arbitration: on contention the lane opposite the previous winner is served.
  always_comb begin
    grant_s = 1'b0;
    win_b_s = 1'b0;
    if ((state_r == IDLE) || (state_r == DONE)) begin
      grant_s = req_a | req_b;
      if (req_a && req_b) begin
        win_b_s = (last_r == LANE_A);
      end else begin
        win_b_s = req_b;
      end
    end else begin
      grant_s = 1'b0;
      win_b_s = 1'b0;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    state_s = grant_s ? CALC : IDLE;
      CALC:    state_s = DONE;
      DONE:    state_s = grant_s ? CALC : IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Next values for the registered outputs and the captured operand.
  always_comb begin
    gnt_a_s    = 1'b0;
    gnt_b_s    = 1'b0;
    done_a_s   = 1'b0;
    done_b_s   = 1'b0;
    result_a_s = result_a;
    result_b_s = result_b;
    ovf_a_s    = ovf_a;
    ovf_b_s    = ovf_b;
    last_s     = last_r;
    lane_s     = lane_r;
    opnd_s     = opnd_r;
    if (grant_s) begin
      gnt_a_s = ~win_b_s;
      gnt_b_s = win_b_s;
      last_s  = win_b_s;
      lane_s  = win_b_s;
      opnd_s  = win_b_s ? {1'b0, b_in} : a_in;
    end else begin
      last_s = last_r;
      lane_s = lane_r;
      opnd_s = opnd_r;
    end
    if (state_r == CALC) begin
      if (lane_r == LANE_B) begin
        done_b_s   = 1'b1;
        result_b_s = sum_s[WIDTH-2:0];
        ovf_b_s    = all_ones(opnd_r, 1'b1);
      end else begin
        done_a_s   = 1'b1;
        result_a_s = sum_s;
        ovf_a_s    = all_ones(opnd_r, 1'b0);
      end
    end else begin
      done_a_s = 1'b0;
      done_b_s = 1'b0;
    end
    busy_s = (state_s != IDLE);
  end

  // State register; reset discards any in-flight operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      last_r  <= LANE_B;
      lane_r  <= LANE_A;
      opnd_r  <= {WIDTH{1'b0}};
    end else begin
      state_r <= state_s;
      last_r  <= last_s;
      lane_r  <= lane_s;
      opnd_r  <= opnd_s;
    end
  end

  // Output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_a    <= 1'b0;
      gnt_b    <= 1'b0;
      done_a   <= 1'b0;
      done_b   <= 1'b0;
      result_a <= {WIDTH{1'b0}};
      result_b <= {(WIDTH-1){1'b0}};
      ovf_a    <= 1'b0;
      ovf_b    <= 1'b0;
      busy     <= 1'b0;
    end else begin
      gnt_a    <= gnt_a_s;
      gnt_b    <= gnt_b_s;
      done_a   <= done_a_s;
      done_b   <= done_b_s;
      result_a <= result_a_s;
      result_b <= result_b_s;
      ovf_a    <= ovf_a_s;
      ovf_b    <= ovf_b_s;
      busy     <= busy_s;
    end
  end

endmodule

// File: tb/tb_incr_share_arbiter.sv
// Randomized bench for incr_share_arbiter, checked against a transaction-level
// schedule model (grant at edge e, completion at e+1, unit free again at e+2).
module tb_incr_share_arbiter;

  localparam int W  = 8;
  localparam int WB = W - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_a, req_b;
  logic [W-1:0]  a_in;
  logic [WB-1:0] b_in;
  logic          gnt_a, gnt_b, done_a, done_b, ovf_a, ovf_b, busy;
  logic [W-1:0]  result_a;
  logic [WB-1:0] result_b;

  incr_share_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .a_in(a_in), .req_b(req_b), .b_in(b_in),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .done_a(done_a), .done_b(done_b),
    .result_a(result_a), .result_b(result_b),
    .ovf_a(ovf_a), .ovf_b(ovf_b), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int edge_n   = 0;

  // Reference model: pending job and the edge from which the unit is free.
  int last_b, free_edge, pend_valid, pend_lane, pend_op, pend_edge;
  logic          exp_gnt_a, exp_gnt_b, exp_done_a, exp_done_b;
  logic          exp_ovf_a, exp_ovf_b, exp_busy;
  logic [W-1:0]  exp_result_a;
  logic [WB-1:0] exp_result_b;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    last_b = 1; free_edge = 0; pend_valid = 0; pend_lane = 0; pend_op = 0; pend_edge = 0;
    exp_gnt_a = 1'b0; exp_gnt_b = 1'b0; exp_done_a = 1'b0; exp_done_b = 1'b0;
    exp_ovf_a = 1'b0; exp_ovf_b = 1'b0; exp_busy = 1'b0;
    exp_result_a = '0; exp_result_b = '0;
  endtask

  task automatic model_edge(input logic ra, input logic rb, input logic [W-1:0] av, input logic [WB-1:0] bv);
    bit done_now, grant_now;
    int win_b;
    exp_gnt_a = 1'b0; exp_gnt_b = 1'b0; exp_done_a = 1'b0; exp_done_b = 1'b0;
    done_now = 0;
    if (pend_valid != 0 && pend_edge == edge_n) begin
      done_now = 1;
      pend_valid = 0;
      if (pend_lane == 0) begin
        exp_done_a   = 1'b1;
        exp_result_a = W'((pend_op + 1) % (1 << W));
        exp_ovf_a    = (pend_op == (1 << W) - 1);
      end else begin
        exp_done_b   = 1'b1;
        exp_result_b = WB'((pend_op + 1) % (1 << WB));
        exp_ovf_b    = (pend_op == (1 << WB) - 1);
      end
    end
    grant_now = (edge_n >= free_edge) && (ra || rb);
    if (grant_now) begin
      if (ra && rb) win_b = (last_b != 0) ? 0 : 1;
      else          win_b = rb ? 1 : 0;
      last_b     = win_b;
      pend_valid = 1;
      pend_lane  = win_b;
      pend_op    = (win_b != 0) ? int'(bv) : int'(av);
      pend_edge  = edge_n + 1;
      free_edge  = edge_n + 2;
      exp_gnt_a  = (win_b == 0);
      exp_gnt_b  = (win_b != 0);
    end
    exp_busy = grant_now || done_now;
  endtask

  task automatic compare_all();
    check_eq("gnt_a",    32'(gnt_a),    32'(exp_gnt_a));
    check_eq("gnt_b",    32'(gnt_b),    32'(exp_gnt_b));
    check_eq("done_a",   32'(done_a),   32'(exp_done_a));
    check_eq("done_b",   32'(done_b),   32'(exp_done_b));
    check_eq("result_a", 32'(result_a), 32'(exp_result_a));
    check_eq("result_b", 32'(result_b), 32'(exp_result_b));
    check_eq("ovf_a",    32'(ovf_a),    32'(exp_ovf_a));
    check_eq("ovf_b",    32'(ovf_b),    32'(exp_ovf_b));
    check_eq("busy",     32'(busy),     32'(exp_busy));
    check_eq("gnt_excl",  32'(gnt_a & gnt_b),   32'd0);
    check_eq("done_excl", 32'(done_a & done_b), 32'd0);
    check_eq("gnt_done_overlap", 32'((gnt_a | gnt_b) & (done_a | done_b)), 32'd0);
  endtask

  task automatic step();
    @(posedge clk);
    edge_n++;
    model_edge(req_a, req_b, a_in, b_in);
    #1;
    compare_all();
  endtask

  // Requesters drop on their grant and re-request with probability p percent.
  task automatic drive(input int p);
    if (exp_gnt_a) req_a = 1'b0;
    if (exp_gnt_b) req_b = 1'b0;
    if (!req_a && (int'($urandom_range(99)) < p)) begin
      req_a = 1'b1;
      a_in  = ($urandom_range(3) == 0) ? {W{1'b1}} : W'($urandom);
    end
    if (!req_b && (int'($urandom_range(99)) < p)) begin
      req_b = 1'b1;
      b_in  = ($urandom_range(3) == 0) ? {WB{1'b1}} : WB'($urandom);
    end
  endtask

  task automatic do_reset();
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    compare_all();
    repeat (2) begin
      @(posedge clk);
      edge_n++;
    end
    #2;
    rst = 1'b0;
    free_edge = edge_n + 1;
  endtask

  initial begin
    int last_lane, n_done, n_gnt;
    logic [W-1:0]  hold_a;
    logic [WB-1:0] hold_b;
    rst = 1'b1; req_a = 1'b0; req_b = 1'b0; a_in = '0; b_in = '0;
    model_reset();
    do_reset();

    // Single A request.
    a_in = 8'h05; req_a = 1'b1;
    step();
    check_eq("single_gnt_a", 32'(gnt_a), 32'd1);
    req_a = 1'b0;
    step();
    check_eq("single_result_a", 32'(result_a), 32'h06);
    check_eq("single_done_a", 32'(done_a), 32'd1);
    step();
    check_eq("single_busy_off", 32'(busy), 32'd0);

    // Wrap on both lanes; lane A result held across the B operation.
    a_in = 8'hFF; req_a = 1'b1;
    step(); req_a = 1'b0;
    step();
    check_eq("wrap_result_a", 32'(result_a), 32'h00);
    check_eq("wrap_ovf_a", 32'(ovf_a), 32'd1);
    b_in = 7'h7F; req_b = 1'b1;
    step(); req_b = 1'b0;
    step();
    check_eq("wrap_result_b", 32'(result_b), 32'h00);
    check_eq("wrap_ovf_b", 32'(ovf_b), 32'd1);
    check_eq("wrap_hold_a", 32'(ovf_a), 32'd1);

    // Contention straight after reset: A first, B two cycles later.
    do_reset();
    a_in = 8'h10; b_in = 7'h20; req_a = 1'b1; req_b = 1'b1;
    step();
    check_eq("cont_first_a", 32'(gnt_a), 32'd1);
    req_a = 1'b0;
    step();
    check_eq("cont_result_a", 32'(result_a), 32'h11);
    step();
    check_eq("cont_then_b", 32'(gnt_b), 32'd1);
    req_b = 1'b0;
    step();
    check_eq("cont_result_b", 32'(result_b), 32'h21);

    // Continuous requests on both lanes: strict alternation.
    req_a = 1'b1; a_in = W'($urandom); req_b = 1'b1; b_in = WB'($urandom);
    last_lane = -1; n_done = 0; n_gnt = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      check_eq("cont_busy", 32'(busy), 32'd1);
      if (gnt_a || gnt_b) begin
        n_gnt++;
        if (last_lane >= 0) check_eq("alternate", 32'(gnt_b), 32'(1 - last_lane));
        last_lane = gnt_b ? 1 : 0;
      end
      if (done_a || done_b) n_done++;
      drive(100);
    end
    check_eq("cont_grants", 32'(n_gnt), 32'd8);
    check_eq("cont_dones", 32'(n_done), 32'd8);
    req_a = 1'b0; req_b = 1'b0;
    repeat (4) step();

    // Reset during CALC of 0x33: no completion, then normal service.
    a_in = 8'h33; req_a = 1'b1;
    step();
    check_eq("midop_gnt_a", 32'(gnt_a), 32'd1);
    req_a = 1'b0;
    do_reset();
    step();
    check_eq("midop_no_done", 32'(done_a), 32'd0);
    check_eq("midop_result_a", 32'(result_a), 32'd0);
    a_in = 8'h40; b_in = 7'h05; req_a = 1'b1; req_b = 1'b1;
    step();
    check_eq("post_rst_winner_a", 32'(gnt_a), 32'd1);
    for (int i = 0; i < 6; i++) begin
      drive(0);
      step();
    end
    check_eq("post_rst_result_b", 32'(result_b), 32'h06);

    // Idle: nothing requested for 10 cycles.
    hold_a = result_a; hold_b = result_b;
    repeat (10) step();
    check_eq("idle_busy", 32'(busy), 32'd0);
    check_eq("idle_hold_a", 32'(result_a), 32'(hold_a));
    check_eq("idle_hold_b", 32'(result_b), 32'(hold_b));

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      drive(40);
      step();
    end
    for (int i = 0; i < 6; i++) begin
      drive(0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
